row_kernel_packer: RTL and testbench
====================================

ROW_KERNEL_PACKER -- requirements
Module: row_kernel_packer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (3-bit pixel, 6x6 matrix, six 2x2 kernels).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  serial beat valid.
REQ-005 in_pix  input  3  matrix pixel, raster order (row-major, column 0 first).
REQ-006 in_ker  input  3  kernel element; meaningful on beats 0..23 only.
REQ-007 in_ready  output  1  beat acceptance; beat accepted when in_valid and in_ready both high.
REQ-008 dst_idle  input  1  downstream idle flag; a send may start only while high.
REQ-009 out_valid  output  1  packed-row valid, registered.
REQ-010 out_row  output  18  packed matrix row, registered.
REQ-011 out_kernel  output  12  packed kernel, registered.
REQ-012 drop  output  1  one-cycle pulse, registered: beat offered while in_ready low.

Function
REQ-013 States SHALL be IDLE, COLLECT, WAIT, SEND; encoding free.
REQ-014 in_ready SHALL be combinational from state: 1 in IDLE and COLLECT, 0 in WAIT and SEND.
REQ-015 A 6-bit beat counter SHALL count accepted beats 0..36; cleared on entering IDLE.
REQ-016 IDLE: accepted beat stores beat 0, counter -> 1, next state COLLECT.
REQ-017 COLLECT: each accepted beat stores at counter index and increments; in_valid low holds all state (gaps of any length allowed).
REQ-018 COLLECT -> WAIT on the edge accepting beat 35 (counter reaches 36).
REQ-019 Pixel of beat n SHALL be written to row n/6, bits [3c+2:3c] with c = n mod 6 (column 0 in LSBs).
REQ-020 Kernel element of beat n<24 SHALL be written to kernel n/4, bits [3e+2:3e] with e = n mod 4; in_ker on beats 24..35 ignored.
REQ-021 WAIT: dst_idle sampled high -> SEND next edge; low -> remain in WAIT indefinitely.
REQ-022 SEND SHALL last exactly 6 cycles with send index 0..5; dst_idle ignored during SEND.
REQ-023 out_valid SHALL be 1 on the 6 cycles following the WAIT->SEND edge, carrying out_row=row[i], out_kernel=kernel[i] for i=0..5, consecutive, no gaps.
REQ-024 After send index 5, state SHALL return to IDLE; in_ready high on the cycle after the last out_valid.
REQ-025 Outside SEND out_valid, out_row, out_kernel SHALL be 0.
REQ-026 Minimum latency: beat 35 accepted at edge N with dst_idle high during cycle N -> first out_valid after edge N+2.
REQ-027 drop SHALL pulse for one cycle (after the edge) for each cycle with in_valid=1 and in_ready=0; dropped beat leaves storage and counter unchanged.
REQ-028 Storage SHALL be overwritten only by accepted beats; a new frame fully rewrites all 36 pixels and 24 kernel elements.
REQ-029 A beat arriving in the same cycle that SEND->IDLE occurs SHALL be dropped (in_ready still 0 that cycle).

Reset
REQ-030 rst_n low SHALL force IDLE, counter 0, send index 0, out_valid 0, out_row 0, out_kernel 0, drop 0, immediately and asynchronously.
REQ-031 Reset mid-COLLECT or mid-SEND SHALL abort the frame; no further out_valid until a complete new 36-beat frame is accepted.
REQ-032 Pixel/kernel storage need not be reset.

Verification
REQ-033 Frame pixels = n mod 8, kernels = (n+1) mod 8, in_valid continuous, dst_idle=1 -> 6 out_valid beats; row0 = 18'o543210, kernel0 = 12'o4321, kernel5 = 12'o0765 (beats 20..23: 5,6,7,0).
REQ-034 Same frame with in_valid gaps of 1-3 cycles every 5 beats -> identical output values, no drop.
REQ-035 dst_idle=0 for 20 cycles after beat 35, then 1 -> no out_valid while low; 6 beats starting 2 cycles after dst_idle rises; in_ready=0 throughout WAIT.
REQ-036 in_valid held high for 40 cycles -> beats 36..39 dropped, 4 drop pulses, output equals 36-beat frame.
REQ-037 rst_n asserted at beat 20, then a full new frame -> only the new frame's 6 rows emitted, no partial output.
REQ-038 Two back-to-back frames, second started the cycle after last out_valid -> both emitted correctly, second frame's values not corrupting first.

Source files
------------

// File: rtl/row_kernel_packer_if.sv
// row_kernel_packer_if: serial beat input, downstream idle flag and packed row/kernel output of the packer
interface row_kernel_packer_if;
  logic        in_valid;
  logic [2:0]  in_pix;
  logic [2:0]  in_ker;
  logic        in_ready;
  logic        dst_idle;
  logic        out_valid;
  logic [17:0] out_row;
  logic [11:0] out_kernel;
  logic        drop;
  modport master (
    output in_valid, in_pix, in_ker, dst_idle,
    input  in_ready, out_valid, out_row, out_kernel, drop
  );
  modport slave (
    input  in_valid, in_pix, in_ker, dst_idle,
    output in_ready, out_valid, out_row, out_kernel, drop
  );
endinterface

// File: rtl/row_kernel_packer.sv
// row_kernel_packer: collects a 36-beat 6x6 pixel frame plus six 2x2 kernels, then emits six packed row/kernel pairs
module row_kernel_packer (
  input logic clk,
  input logic rst_n,
  row_kernel_packer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT, SEND} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2:0] idx;
  logic armed;
  logic accept;
  logic [2:0] row_i, col_i;
  logic [5:0][17:0] rows;
  logic [5:0][11:0] kers;
  assign bus.in_ready = (state == IDLE) || (state == COLLECT);
  assign accept = bus.in_valid && bus.in_ready;
  assign row_i = 3'(cnt / 6'd6);
  assign col_i = 3'(cnt % 6'd6);
  always_ff @(posedge clk) begin
    if (accept) begin
      rows[row_i][5'(col_i) * 5'd3 +: 3] <= bus.in_pix;
      if (cnt < 6'd24) kers[cnt[4:2]][4'(cnt[1:0]) * 4'd3 +: 3] <= bus.in_ker;
    end
  end
  // armed records a high dst_idle seen in WAIT; the send starts on the edge after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      armed          <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_row    <= '0;
      bus.out_kernel <= '0;
      bus.drop       <= 1'b0;
    end else begin
      bus.drop <= bus.in_valid && !bus.in_ready;
      case (state)
        IDLE: if (accept) begin
          cnt   <= cnt + 6'd1;
          state <= COLLECT;
        end
        COLLECT: if (accept) begin
          cnt   <= cnt + 6'd1;
          state <= (cnt == 6'd35) ? WAIT : COLLECT;
        end
        WAIT: if (armed) begin
          state          <= SEND;
          armed          <= 1'b0;
          idx            <= '0;
          bus.out_valid  <= 1'b1;
          bus.out_row    <= rows[0];
          bus.out_kernel <= kers[0];
        end else begin
          armed <= bus.dst_idle;
        end
        SEND: if (idx == 3'd5) begin
          state          <= IDLE;
          cnt            <= '0;
          idx            <= '0;
          bus.out_valid  <= 1'b0;
          bus.out_row    <= '0;
          bus.out_kernel <= '0;
        end else begin
          idx            <= idx + 3'd1;
          bus.out_row    <= rows[idx + 3'd1];
          bus.out_kernel <= kers[idx + 3'd1];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_row_kernel_packer.sv
// tb_row_kernel_packer: directed frames against a packing model and hand-computed constants
module tb_row_kernel_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int drops = 0;
  logic [17:0] q_row[$];
  logic [11:0] q_ker[$];
  int q_t[$];
  row_kernel_packer_if bus();
  row_kernel_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_row.push_back(bus.out_row);
      q_ker.push_back(bus.out_kernel);
      q_t.push_back(cyc);
    end
    if (bus.drop === 1'b1) drops++;
  end
  function automatic logic [2:0] pix_of(int sel, int n);
    return (sel == 0) ? 3'(n % 8) : 3'((3 * n + 1) % 8);
  endfunction
  function automatic logic [2:0] ker_of(int sel, int n);
    return (sel == 0) ? 3'((n + 1) % 8) : 3'((5 * n + 2) % 8);
  endfunction
  function automatic logic [17:0] exp_row(int sel, int r);
    logic [17:0] v;
    for (int c = 0; c < 6; c++) v[3*c +: 3] = pix_of(sel, 6 * r + c);
    return v;
  endfunction
  function automatic logic [11:0] exp_ker(int sel, int k);
    logic [11:0] v;
    for (int e = 0; e < 4; e++) v[3*e +: 3] = ker_of(sel, 4 * k + e);
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    q_row.delete();
    q_ker.delete();
    q_t.delete();
    drops = 0;
  endtask
  task automatic wait_rows(input int n);
    for (int t = 0; t < 80 && q_row.size() < n; t++) step();
  endtask
  task automatic send_frame(input int sel, input bit gaps, input int nb, output int last);
    last = -1;
    for (int n = 0; n < nb; n++) begin
      bus.in_valid = 1'b1;
      bus.in_pix = pix_of(sel, n);
      bus.in_ker = ker_of(sel, n);
      vecs++;
      if (bus.in_ready !== 1'(n < 36)) begin
        errs++;
        $display("FAIL in_ready beat %0d got %b want %b", n, bus.in_ready, 1'(n < 36));
      end
      step();
      if (n == 35) last = cyc;
      if (gaps && n % 5 == 4 && n < 35) begin
        bus.in_valid = 1'b0;
        repeat (1 + (n / 5) % 3) step();
      end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.dst_idle = 1'b1;
    step();
    step();
    vecs++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.out_row !== 18'd0 || bus.out_kernel !== 12'd0) begin
      errs++;
      $display("FAIL reset outputs got v=%b row=%o ker=%o want 0", bus.out_valid, bus.out_row, bus.out_kernel);
    end
    vecs++;
    if (bus.drop !== 1'b0) begin errs++; $display("FAIL reset drop got %b want 0", bus.drop); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_basic(input bit gaps);
    int last;
    logic [17:0] r;
    logic [11:0] k;
    clear_mon();
    bus.dst_idle = 1'b1;
    send_frame(0, gaps, 36, last);
    wait_rows(6);
    vecs++;
    if (q_row.size() != 6) begin errs++; $display("FAIL basic%0d count got %0d want 6", gaps, q_row.size()); end
    vecs++;
    if (q_t.size() != 6 || q_t[0] != last + 2 || q_t[5] != q_t[0] + 5) begin
      errs++;
      $display("FAIL basic%0d timing first=%0d want %0d", gaps, q_t.size() ? q_t[0] : -1, last + 2);
    end
    for (int i = 0; i < 6; i++) begin
      r = (i < q_row.size()) ? q_row[i] : 'x;
      k = (i < q_ker.size()) ? q_ker[i] : 'x;
      vecs++;
      if (r !== exp_row(0, i) || k !== exp_ker(0, i)) begin
        errs++;
        $display("FAIL basic%0d row%0d got %o/%o want %o/%o", gaps, i, r, k, exp_row(0, i), exp_ker(0, i));
      end
    end
    vecs++;
    if (q_row.size() == 6 && (q_row[0] !== 18'o543210 || q_ker[0] !== 12'o4321 || q_ker[5] !== 12'o0765)) begin
      errs++;
      $display("FAIL basic%0d consts got %o %o %o want 543210 4321 0765", gaps, q_row[0], q_ker[0], q_ker[5]);
    end
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_row !== 18'd0 || bus.out_kernel !== 12'd0) begin
      errs++;
      $display("FAIL basic%0d after rdy=%b v=%b row=%o ker=%o want 1 0 0 0", gaps, bus.in_ready, bus.out_valid, bus.out_row, bus.out_kernel);
    end
    vecs++;
    if (drops != 0) begin errs++; $display("FAIL basic%0d drops got %0d want 0", gaps, drops); end
  endtask
  task automatic test_wait();
    int last;
    int rise;
    logic [17:0] r;
    clear_mon();
    bus.dst_idle = 1'b0;
    send_frame(0, 0, 36, last);
    for (int i = 0; i < 20; i++) begin
      vecs++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL wait hold%0d rdy=%b v=%b want 0 0", i, bus.in_ready, bus.out_valid);
      end
      step();
    end
    rise = cyc;
    bus.dst_idle = 1'b1;
    wait_rows(6);
    vecs++;
    if (q_t.size() != 6 || q_t[0] != rise + 2) begin
      errs++;
      $display("FAIL wait timing n=%0d first=%0d want 6 @%0d", q_t.size(), q_t.size() ? q_t[0] : -1, rise + 2);
    end
    for (int i = 0; i < 6; i++) begin
      r = (i < q_row.size()) ? q_row[i] : 'x;
      vecs++;
      if (r !== exp_row(0, i)) begin errs++; $display("FAIL wait row%0d got %o want %o", i, r, exp_row(0, i)); end
    end
  endtask
  task automatic test_overrun();
    int last;
    logic [17:0] r;
    logic [11:0] k;
    clear_mon();
    bus.dst_idle = 1'b1;
    send_frame(0, 0, 40, last);
    wait_rows(6);
    vecs++;
    if (drops != 4) begin errs++; $display("FAIL overrun drops got %0d want 4", drops); end
    for (int i = 0; i < 6; i++) begin
      r = (i < q_row.size()) ? q_row[i] : 'x;
      k = (i < q_ker.size()) ? q_ker[i] : 'x;
      vecs++;
      if (r !== exp_row(0, i) || k !== exp_ker(0, i)) begin
        errs++;
        $display("FAIL overrun row%0d got %o/%o want %o/%o", i, r, k, exp_row(0, i), exp_ker(0, i));
      end
    end
  endtask
  task automatic test_back_to_back();
    int last;
    int t;
    logic [17:0] r;
    logic [11:0] k;
    clear_mon();
    bus.dst_idle = 1'b1;
    send_frame(0, 0, 36, last);
    t = 0;
    while (t < 60 && !(bus.out_valid === 1'b1 && q_row.size() == 5)) begin step(); t++; end
    bus.in_valid = 1'b1;
    bus.in_pix = 3'd7;
    bus.in_ker = 3'd7;
    step();
    bus.in_valid = 1'b0;
    vecs++;
    if (bus.drop !== 1'b1 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b last-send beat drop=%b rdy=%b want 1 1", bus.drop, bus.in_ready);
    end
    send_frame(1, 0, 36, last);
    wait_rows(12);
    for (int i = 0; i < 12; i++) begin
      r = (i < q_row.size()) ? q_row[i] : 'x;
      k = (i < q_ker.size()) ? q_ker[i] : 'x;
      vecs++;
      if (r !== exp_row(i / 6, i % 6) || k !== exp_ker(i / 6, i % 6)) begin
        errs++;
        $display("FAIL b2b row%0d got %o/%o want %o/%o", i, r, k, exp_row(i / 6, i % 6), exp_ker(i / 6, i % 6));
      end
    end
  endtask
  task automatic test_reset_abort();
    int last;
    int sz;
    logic [17:0] r;
    clear_mon();
    bus.dst_idle = 1'b1;
    send_frame(1, 0, 20, last);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    send_frame(0, 0, 36, last);
    wait_rows(6);
    repeat (10) step();
    vecs++;
    if (q_row.size() != 6) begin errs++; $display("FAIL abort count got %0d want 6", q_row.size()); end
    for (int i = 0; i < 6; i++) begin
      r = (i < q_row.size()) ? q_row[i] : 'x;
      vecs++;
      if (r !== exp_row(0, i)) begin errs++; $display("FAIL abort row%0d got %o want %o", i, r, exp_row(0, i)); end
    end
    clear_mon();
    send_frame(1, 0, 36, last);
    wait_rows(2);
    sz = q_row.size();
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.out_row !== 18'd0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort async v=%b row=%o rdy=%b want 0 0 1", bus.out_valid, bus.out_row, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    repeat (15) step();
    vecs++;
    if (q_row.size() != sz) begin errs++; $display("FAIL abort send rows got %0d want %0d", q_row.size(), sz); end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_pix = 3'd0;
    bus.in_ker = 3'd0;
    bus.dst_idle = 1'b1;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_wait();
    test_overrun();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
